// File: rtl/shift_acc.sv
// Bit-serial shift accumulator: sums per-bit-plane partial sums (psum << sel) into one dot product.
// Define SHIFT_ACC_SIGNED_EN to subtract the final (sign) plane for two's-complement inputs.
module shift_acc #(
   parameter int PSW = 16,
   parameter int OW  = 40
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  st,
   input  logic                  sus,
   input  logic [5:0]            sel,
   input  logic signed [PSW-1:0] psum,
   input  logic                  out_rdy,
   output logic                  out_vld,
   output logic [OW-1:0]         result,
   output logic                  busy,
   output logic                  ovf,
   output logic                  seq_err
);

   // Handshake: result is held while out_vld=1 and is consumed on any edge where out_rdy=1;
   // a completion in that same edge reloads result and keeps out_vld high.
   typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

   state_t        r_state;
   logic [OW-1:0] r_acc;
   logic [5:0]    r_exp;
   logic [OW-1:0] r_result;
   logic          r_out_vld;
   logic          r_ovf;
   logic          r_seq_err;

   logic [OW-1:0] w_ext;
   logic [OW-1:0] w_term;
   logic [OW-1:0] w_base;
   logic [OW-1:0] w_acc_next;
   logic [OW-1:0] w_final;
   logic          w_start;
   logic          w_accum;
   logic          w_done;
   logic          w_seq_bad;

   assign w_ext      = {{(OW-PSW){psum[PSW-1]}}, psum};
   assign w_term     = w_ext << sel;
   assign w_base     = (r_state == ACC) ? r_acc : '0;
   assign w_acc_next = w_base + w_term;
`ifdef SHIFT_ACC_SIGNED_EN
   assign w_final    = w_base - w_term;
`else
   assign w_final    = w_base + w_term;
`endif

   assign w_start   = (r_state == IDLE) && !st && (sel == 6'd0);
   assign w_accum   = w_start || ((r_state == ACC) && !st);
   assign w_done    = w_accum && sus;
   // r_exp is held at 0 in IDLE, so one compare covers both the start and in-run ordering checks.
   assign w_seq_bad = !st && (sel != r_exp);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state   <= IDLE;
         r_acc     <= '0;
         r_exp     <= '0;
         r_result  <= '0;
         r_out_vld <= 1'b0;
         r_ovf     <= 1'b0;
         r_seq_err <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_start && !sus) begin
                  r_state <= ACC;
                  r_acc   <= w_term;
                  r_exp   <= 6'd1;
               end
            end
            ACC: begin
               if (st || sus) begin
                  r_state <= IDLE;
                  r_acc   <= '0;
                  r_exp   <= '0;
               end else begin
                  r_acc <= w_acc_next;
                  r_exp <= r_exp + 6'd1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_acc   <= '0;
               r_exp   <= '0;
            end
         endcase

         if (w_seq_bad)
            r_seq_err <= 1'b1;

         if (w_done) begin
            r_result  <= w_final;
            r_out_vld <= 1'b1;
            if (r_out_vld && !out_rdy)
               r_ovf <= 1'b1;
         end else if (out_rdy) begin
            r_out_vld <= 1'b0;
         end
      end
   end

   assign out_vld = r_out_vld;
   assign result  = r_result;
   assign busy    = (r_state == ACC);
   assign ovf     = r_ovf;
   assign seq_err = r_seq_err;

endmodule

// File: tb/tb_shift_acc.sv
// Self-checking bench for shift_acc: directed plane sequences plus random runs against a
// plane-sum reference model; honours SHIFT_ACC_SIGNED_EN.
module tb_shift_acc;
   localparam int PSW = 16;
   localparam int OW  = 40;

   logic           clk = 1'b0;
   logic           rstn;
   logic           st;
   logic           sus;
   logic [5:0]     sel;
   logic [PSW-1:0] psum;
   logic           out_rdy;
   logic           out_vld;
   logic [OW-1:0]  result;
   logic           busy;
   logic           ovf;
   logic           seq_err;

   shift_acc #(.PSW(PSW), .OW(OW)) dut (
      .clk(clk), .rstn(rstn), .st(st), .sus(sus), .sel(sel), .psum(psum),
      .out_rdy(out_rdy), .out_vld(out_vld), .result(result), .busy(busy),
      .ovf(ovf), .seq_err(seq_err)
   );

   always #5 clk = ~clk;

   int            n_checks = 0;
   int            n_errors = 0;
   int            busy_cnt = 0;
   int            r_sel[24];
   int            r_ps[24];
   logic [OW-1:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: result = sum over planes of psum_i * 2^sel_i, last plane negated in signed mode.
   function automatic logic [OW-1:0] ref_run(input int n);
      longint acc = 0;
      longint t;
      for (int i = 0; i < n; i++) begin
         t = longint'(r_ps[i]) * (longint'(1) << r_sel[i]);
`ifdef SHIFT_ACC_SIGNED_EN
         if (i == n - 1) acc -= t;
         else            acc += t;
`else
         acc += t;
`endif
      end
      return acc[OW-1:0];
   endfunction

   task automatic drive(input logic st_v, input logic sus_v, input int sel_v, input int ps_v);
      st   = st_v;
      sus  = sus_v;
      sel  = 6'(sel_v);
      psum = ps_v[PSW-1:0];
      @(posedge clk);
      #1;
      if (busy) busy_cnt++;
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) drive(1'b1, 1'b0, 0, 0);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      idle(2);
      rstn = 1'b1;
   endtask

   task automatic fill(input int n, input int ps_v);
      for (int i = 0; i < n; i++) begin
         r_sel[i] = i;
         r_ps[i]  = ps_v;
      end
   endtask

   task automatic run_and_check(input string tag, input int n);
      exp_q.push_back(ref_run(n));
      busy_cnt = 0;
      for (int i = 0; i < n; i++) drive(1'b0, i == n - 1, r_sel[i], r_ps[i]);
      check_eq({tag, "_vld"}, OW'(out_vld), OW'(1));
      check_eq({tag, "_res"}, result, exp_q.pop_front());
      check_eq({tag, "_busy"}, OW'(busy_cnt), OW'(n - 1));
   endtask

   initial begin
      logic signed [PSW-1:0] rnd;
      int n;
      rstn = 1'b0; st = 1'b1; sus = 1'b0; sel = '0; psum = '0; out_rdy = 1'b1;
      do_reset();
      check_eq("rst_vld", OW'(out_vld), '0);
      check_eq("rst_res", result, '0);
      check_eq("rst_busy", OW'(busy), '0);
      check_eq("rst_ovf", OW'(ovf), '0);
      check_eq("rst_seq", OW'(seq_err), '0);

      fill(12, 1);
      run_and_check("p12_one", 12);
`ifdef SHIFT_ACC_SIGNED_EN
      check_eq("p12_one_const", result, 40'hFF_FFFF_FFFF);
      idle(1);
      fill(12, -2);
      run_and_check("p12_m2", 12);
      check_eq("p12_m2_const", result, 40'd2);
`else
      check_eq("p12_one_const", result, 40'd4095);
`endif
      idle(1);
      check_eq("consumed_vld", OW'(out_vld), '0);

      fill(24, 3);
      run_and_check("p24_three", 24);
`ifndef SHIFT_ACC_SIGNED_EN
      check_eq("p24_const", result, 40'd50331645);
`endif
      check_eq("p24_busy_cnt", OW'(busy_cnt), OW'(23));
      idle(2);

      // Abort mid-run: sel 0..4 accumulate, then st=1 where sel 5 would have been.
      for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, i, 7);
      check_eq("pre_abort_busy", OW'(busy), OW'(1));
      drive(1'b1, 1'b0, 5, 7);
      check_eq("abort_busy", OW'(busy), '0);
      check_eq("abort_vld", OW'(out_vld), '0);
      check_eq("abort_seq", OW'(seq_err), '0);
      check_eq("abort_ovf", OW'(ovf), '0);
      idle(2);
      check_eq("abort_vld_late", OW'(out_vld), '0);

      // Out-of-order plane: 0,1,2,3,5,6,7,8 still accumulates with the given sel.
      fill(8, 5);
      for (int i = 4; i < 8; i++) r_sel[i] = i + 1;
      run_and_check("skip", 8);
      check_eq("skip_seq", OW'(seq_err), OW'(1));
      idle(2);

      // Overwrite of an unread result.
      out_rdy = 1'b0;
      fill(12, 1);
      run_and_check("ovf_run1", 12);
      check_eq("ovf_after1", OW'(ovf), '0);
      fill(12, 2);
      run_and_check("ovf_run2", 12);
`ifndef SHIFT_ACC_SIGNED_EN
      check_eq("ovf_const", result, 40'd8190);
`endif
      check_eq("ovf_set", OW'(ovf), OW'(1));
      idle(3);
      check_eq("ovf_hold_vld", OW'(out_vld), OW'(1));
      out_rdy = 1'b1;
      idle(1);
      check_eq("ovf_drain_vld", OW'(out_vld), '0);
      check_eq("ovf_sticky", OW'(ovf), OW'(1));

      // Reset in the middle of a run with a result pending.
      out_rdy = 1'b0;
      fill(1, 9);
      run_and_check("pend", 1);
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, i, 11);
      rstn = 1'b0;
      drive(1'b0, 1'b0, 4, 11);
      check_eq("mid_rst_vld", OW'(out_vld), '0);
      check_eq("mid_rst_res", result, '0);
      check_eq("mid_rst_busy", OW'(busy), '0);
      check_eq("mid_rst_ovf", OW'(ovf), '0);
      check_eq("mid_rst_seq", OW'(seq_err), '0);
      rstn = 1'b1;
      out_rdy = 1'b1;
      idle(2);

      for (int k = 0; k < 40; k++) begin
         n = $urandom_range(1, 24);
         for (int i = 0; i < n; i++) begin
            rnd = PSW'($urandom);
            r_sel[i] = i;
            r_ps[i]  = int'(rnd);
         end
         run_and_check($sformatf("rnd%0d", k), n);
         idle($urandom_range(0, 2));
      end
      check_eq("rnd_ovf", OW'(ovf), '0);
      check_eq("rnd_seq", OW'(seq_err), '0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
